// File: rtl/sram_sp_hdc_svt_rvt_hvt_model_if.sv
// Access bus of the single-port SRAM macro model.
// Pin names match the foundry HD macro.
interface sram_sp_hdc_svt_rvt_hvt_model_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                  CEN;
   logic                  WEN;
   logic [ADDR_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] D;
   logic [2:0]            EMA;
   logic                  RETN;
   logic [DATA_WIDTH-1:0] Q;

   modport master (
      output CEN, WEN, A, D, EMA, RETN,
      input  Q
   );

   modport slave (
      input  CEN, WEN, A, D, EMA, RETN,
      output Q
   );
endinterface

// File: rtl/sram_sp_hdc_svt_rvt_hvt_model.sv
// Behavioural single-port synchronous SRAM: one read or write per edge.
// Registered Q, write-through, retention freezes the array.
module sram_sp_hdc_svt_rvt_hvt_model #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input logic CLK,
   input logic RST,
   sram_sp_hdc_svt_rvt_hvt_model_if.slave bus
);

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
   logic [DATA_WIDTH-1:0] q_r = '0;

   logic x_ctl;
   logic acc;
   logic wr;

   // Unknown control only matters in 4-state simulation; it is 0 in hardware.
   assign x_ctl = $isunknown({bus.CEN, bus.RETN})
               || (bus.CEN == 1'b0 && $isunknown({bus.WEN, bus.A}));

   assign acc = !RST && bus.RETN && !bus.CEN;
   assign wr  = acc && !bus.WEN;

   always_ff @(posedge CLK) begin
      if (!RST && x_ctl && bus.WEN !== 1'b1) begin
         mem[bus.A] <= 'x;
      end else if (wr) begin
         mem[bus.A] <= bus.D;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_r <= '0;
      end else if (x_ctl) begin
         q_r <= 'x;
      end else if (!bus.RETN) begin
         q_r <= '0;
      end else if (!bus.CEN) begin
         if (!bus.WEN) begin
            q_r <= bus.D;
         end else begin
            q_r <= mem[bus.A];
         end
      end
   end

   assign bus.Q = q_r;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (!x_ctl)
            else $error("sram: X/Z on CEN/WEN/A/RETN at access edge");
         if (bus.CEN == 1'b0) begin
            assert (!$isunknown(bus.EMA))
               else $error("sram: X/Z on EMA during access");
         end
      end
   end

endmodule

// File: tb/tb_sram_sp_hdc_svt_rvt_hvt_model.sv
// Scoreboard bench for the single-port SRAM model.
// Expected Q values are queued at drive time and compared after the edge.
module tb_sram_sp_hdc_svt_rvt_hvt_model;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst;

   sram_sp_hdc_svt_rvt_hvt_model_if #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) bus ();

   sram_sp_hdc_svt_rvt_hvt_model #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH     (DEPTH)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int tests;
   int fails;
   logic [DW-1:0] sb [$];
   logic [DW-1:0] m [DEPTH];
   logic [DW-1:0] qm;

   // Drives one edge and keeps the reference model in step with it.
   task automatic drive(input logic r, input logic retn, input logic cen,
                        input logic wen, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [2:0] ema);
      rst = r;
      bus.RETN = retn;
      bus.CEN = cen;
      bus.WEN = wen;
      bus.A = a;
      bus.D = d;
      bus.EMA = ema;
      if (r) qm = '0;
      else if (!retn) qm = '0;
      else if (!cen) begin
         if (!wen) begin
            m[a] = d;
            qm = d;
         end else begin
            qm = m[a];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [DW-1:0] e;
      tests++;
      if (bus.Q !== 32'h0) begin
         fails++;
         $display("FAIL q_time0: got %h want %h", bus.Q, 32'h0);
      end
      sb.push_back(32'h0);
      drive(1, 1, 1, 1, 0, 0, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL reset_q: got %h want %h", bus.Q, e);
      end
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      logic [DW-1:0] e;
      sb.push_back(32'hF);
      drive(0, 1, 0, 0, 10'hF, 32'hF, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL wr_through: got %h want %h", bus.Q, e);
      end
      sb.push_back(32'h0000000F);
      drive(0, 1, 0, 1, 10'hF, 32'h0, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL rd_after_wr: got %h want %h", bus.Q, e);
      end
   endtask

   task automatic test_standby();
      logic [DW-1:0] e;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(32'hF);
         drive(0, 1, 1, 0, 10'h0, 32'h0, 0);
         e = sb.pop_front();
         tests++;
         if (bus.Q !== e) begin
            fails++;
            $display("FAIL standby_hold%0d: got %h want %h", i, bus.Q, e);
         end
      end
      sb.push_back(32'hF);
      drive(0, 1, 0, 1, 10'hF, 32'h0, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL standby_rd: got %h want %h", bus.Q, e);
      end
      sb.push_back(32'h0);
      drive(0, 1, 0, 1, 10'h0, 32'h0, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL standby_nowr: got %h want %h", bus.Q, e);
      end
   endtask

   task automatic test_retention();
      logic [DW-1:0] e;
      sb.push_back(32'h0);
      drive(0, 0, 0, 0, 10'hF, 32'h0, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL retn_q: got %h want %h", bus.Q, e);
      end
      sb.push_back(32'h0000000F);
      drive(0, 1, 0, 1, 10'hF, 32'h0, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL retn_kept: got %h want %h", bus.Q, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e;
      logic [DW-1:0] dd;
      for (int k = 0; k < 8; k++) begin
         dd = 32'hAAAA5555 ^ k;
         sb.push_back(dd);
         drive(0, 1, 0, 0, 10'h000, dd, 3'(k));
         sb.push_back(~dd);
         drive(0, 1, 0, 0, 10'h3FF, ~dd, 3'(k));
         sb.push_back(dd);
         drive(0, 1, 0, 1, 10'h000, 32'h0, 3'(k));
         e = sb.pop_front();
         e = sb.pop_front();
         e = sb.pop_front();
         tests++;
         if (bus.Q !== e) begin
            fails++;
            $display("FAIL b2b_rd0 ema%0d: got %h want %h", k, bus.Q, e);
         end
         sb.push_back(~dd);
         drive(0, 1, 0, 1, 10'h3FF, 32'h0, 3'(k));
         e = sb.pop_front();
         tests++;
         if (bus.Q !== e) begin
            fails++;
            $display("FAIL b2b_rd3ff ema%0d: got %h want %h", k, bus.Q, e);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [DW-1:0] e;
      sb.push_back(32'h0);
      drive(1, 1, 0, 0, 10'hF, 32'h12345678, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL rst_mid_q: got %h want %h", bus.Q, e);
      end
      sb.push_back(32'h0000000F);
      drive(0, 1, 0, 1, 10'hF, 32'h0, 0);
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e) begin
         fails++;
         $display("FAIL rst_mid_nowr: got %h want %h", bus.Q, e);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] e;
      logic [AW-1:0] a;
      int errs;
      errs = 0;
      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 15) != 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               a, $urandom, 3'($urandom));
         sb.push_back(qm);
         e = sb.pop_front();
         tests++;
         if (bus.Q !== e) begin
            fails++;
            if (errs < 10)
               $display("FAIL rand%0d: got %h want %h", i, bus.Q, e);
            errs++;
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      qm = '0;
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      rst = 1'b0;
      bus.CEN = 1'b1;
      bus.WEN = 1'b1;
      bus.A = '0;
      bus.D = '0;
      bus.EMA = '0;
      bus.RETN = 1'b1;
      #1;
      test_reset();
      test_write_read();
      test_standby();
      test_retention();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_empty: got %0d want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
